// File: rtl/branch_sequencer.sv
// ----------------------------------------------------------------------------
// branch_sequencer
//   Program-counter sequencer with a four-state run control FSM, absolute
//   unconditional/conditional branching on registered Z/N flags, a one-cycle
//   taken pulse and a saturating retired-instruction counter.
//
//   Optional feature macro: FLAG_BYPASS_EN
//     defined   : a conditional branch in a retiring cycle with flag_we=1
//                 tests alu_z/alu_n directly (same-cycle forwarding).
//     undefined : conditional branches always test the registered flags.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     run, halt_req     start/resume and halt requests (halt wins)
//     stall             hold current instruction, no retire
//     branch, branch_if unconditional / conditional branch
//     brx               condition select (1 = N flag, 0 = Z flag)
//     flag_we           capture alu_z/alu_n on retire
//     alu_z, alu_n      ALU zero / negative results
//     target            absolute branch target
//     pc                current instruction address
//     instr_valid       high while state is RUN
//     flag_z, flag_n    registered condition flags
//     taken             pulse, cycle after a taken branch retires
//     state             IDLE=00, RUN=01, STALL=10, HALT=11
//     retired           saturating retired-instruction count
// ----------------------------------------------------------------------------
module branch_sequencer #(
    parameter int unsigned            PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                halt_req,
    input  logic                stall,
    input  logic                branch,
    input  logic                branch_if,
    input  logic                brx,
    input  logic                flag_we,
    input  logic                alu_z,
    input  logic                alu_n,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                instr_valid,
    output logic                flag_z,
    output logic                flag_n,
    output logic                taken,
    output logic [1:0]          state,
    output logic [15:0]         retired
);

    localparam int unsigned RET_WIDTH = 16;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    logic [1:0]           r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic                 r_flag_z;
    logic                 r_flag_n;
    logic                 r_taken;
    logic                 r_instr_valid;
    logic [RET_WIDTH-1:0] r_retired;

    logic [1:0]           w_state_nxt;
    logic                 w_retire;
    logic                 w_start;
    logic                 w_zsel;
    logic                 w_nsel;
    logic                 w_cond;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, retire qualification and branch condition
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_start     = 1'b0;
        w_zsel      = r_flag_z;
        w_nsel      = r_flag_n;
        w_cond      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run && !halt_req) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (stall) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_retire = 1'b1;
                end
            end
            ST_STALL: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (!stall) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (run && !halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef FLAG_BYPASS_EN
        // Forward the ALU flags being written this cycle into the branch test
        if (flag_we) begin
            w_zsel = alu_z;
            w_nsel = alu_n;
        end
`endif

        w_cond = branch | (branch_if & (brx ? w_nsel : w_zsel));
    end

    // PC, flags, taken pulse and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_flag_z      <= 1'b0;
            r_flag_n      <= 1'b0;
            r_taken       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_instr_valid <= (w_state_nxt == ST_RUN);
            r_taken       <= w_retire & w_cond;
            if (w_retire) begin
                r_pc <= w_cond ? target : r_pc + PC_WIDTH'(1);
                if (flag_we) begin
                    r_flag_z <= alu_z;
                    r_flag_n <= alu_n;
                end
                if (r_retired != {RET_WIDTH{1'b1}}) begin
                    r_retired <= r_retired + RET_WIDTH'(1);
                end
            end else if (w_start) begin
                r_pc <= RESET_VECTOR;
            end
        end
    end

    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign flag_z      = r_flag_z;
    assign flag_n      = r_flag_n;
    assign taken       = r_taken;
    assign state       = r_state;
    assign retired     = r_retired;

endmodule

// File: tb/tb_branch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_branch_sequencer
//   Scoreboard bench: the stimulus process drives one input set per clock,
//   advances a behavioural model of the sequencer and queues the outputs it
//   expects after that edge; a separate monitor pops and compares on the
//   falling edge. Directed scenarios come first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam int unsigned PW = 8;
    localparam logic [PW-1:0] RV = 8'h00;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam int M_HALT  = 3;

    typedef struct {
        int pc;
        int iv;
        int fz;
        int fn;
        int tk;
        int st;
        int ret;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          run, halt_req, stall, branch, branch_if, brx, flag_we;
    logic          alu_z, alu_n;
    logic [PW-1:0] target;
    logic [PW-1:0] pc;
    logic          instr_valid, flag_z, flag_n, taken;
    logic [1:0]    state;
    logic [15:0]   retired;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    // model state
    int m_mode, m_pc, m_fz, m_fn, m_tk, m_ret;

    branch_sequencer #(.PC_WIDTH(PW), .RESET_VECTOR(RV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .halt_req   (halt_req),
        .stall      (stall),
        .branch     (branch),
        .branch_if  (branch_if),
        .brx        (brx),
        .flag_we    (flag_we),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .target     (target),
        .pc         (pc),
        .instr_valid(instr_valid),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .taken      (taken),
        .state      (state),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_pc   = int'(RV);
        m_fz   = 0;
        m_fn   = 0;
        m_tk   = 0;
        m_ret  = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pc  = m_pc;
        e.iv  = (m_mode == M_RUN) ? 1 : 0;
        e.fz  = m_fz;
        e.fn  = m_fn;
        e.tk  = m_tk;
        e.st  = m_mode;
        e.ret = m_ret;
        return e;
    endfunction

    // One clock edge of the sequencer, described from the behavioural rules
    function automatic void model_edge(int r, int h, int s, int b, int bi, int bx,
                                       int fw, int z, int n, int t);
        int zs, ns, c, go;
        go = (m_mode == M_RUN && s == 0 && h == 0) ? 1 : 0;
        m_tk = 0;
        if (go != 0) begin
            zs = m_fz;
            ns = m_fn;
`ifdef FLAG_BYPASS_EN
            if (fw != 0) begin
                zs = z;
                ns = n;
            end
`endif
            c = (b != 0 || (bi != 0 && ((bx != 0) ? ns : zs) != 0)) ? 1 : 0;
            m_pc = (c != 0) ? t : (m_pc + 1) % 256;
            if (fw != 0) begin
                m_fz = z;
                m_fn = n;
            end
            m_tk = c;
            if (m_ret < 65535) m_ret = m_ret + 1;
        end
        if (h != 0) begin
            if (m_mode == M_RUN || m_mode == M_STALL) m_mode = M_HALT;
        end else if (m_mode == M_IDLE && r != 0) begin
            m_mode = M_RUN;
            m_pc   = int'(RV);
        end else if (m_mode == M_RUN && s != 0) begin
            m_mode = M_STALL;
        end else if (m_mode == M_STALL && s == 0) begin
            m_mode = M_RUN;
        end else if (m_mode == M_HALT && r != 0) begin
            m_mode = M_RUN;
        end
    endfunction

    function automatic void chk(string nm, int act, int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endfunction

    // Drive one input set, let one edge pass, queue the expected outputs
    task automatic cyc(input int r, input int h, input int s, input int b, input int bi,
                       input int bx, input int fw, input int z, input int n, input int t);
        run       = 1'(r);
        halt_req  = 1'(h);
        stall     = 1'(s);
        branch    = 1'(b);
        branch_if = 1'(bi);
        brx       = 1'(bx);
        flag_we   = 1'(fw);
        alu_z     = 1'(z);
        alu_n     = 1'(n);
        target    = PW'(t);
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge(r, h, s, b, bi, bx, fw, z, n, t);
        q.push_back(model_out());
    endtask

    task automatic plain();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic async_rst();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        q.push_back(model_out());
        #4 rst_n = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",          int'(pc),          e.pc);
                chk("instr_valid", int'(instr_valid), e.iv);
                chk("flag_z",      int'(flag_z),      e.fz);
                chk("flag_n",      int'(flag_n),      e.fn);
                chk("taken",       int'(taken),       e.tk);
                chk("state",       int'(state),       e.st);
                chk("retired",     int'(retired),     e.ret);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 1, 1, 1, 8'h33);
        rst_n = 1'b1;

        // start and ten plain retires
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) plain();

        // pc wrap and unconditional branch
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'hFF);
        plain();
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h40);
        plain();

        // conditional on registered flags
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h20);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 8'h55);

        // flag write and conditional branch in the same cycle
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1, 1, 0, 8'h77);
        plain();

        // stall and halt together, then resume
        cyc(0, 1, 1, 1, 0, 0, 1, 1, 1, 8'h11);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 1, 8'h22);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        plain();

        // stall, then asynchronous reset mid-stall
        cyc(0, 0, 1, 1, 0, 0, 1, 1, 1, 8'h99);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        async_rst();
        plain();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        plain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(int'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? 1 : 0,
                ($urandom_range(0, 4) == 0) ? 1 : 0,
                ($urandom_range(0, 5) == 0) ? 1 : 0,
                ($urandom_range(0, 2) == 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)));
            if (i % 700 == 350) async_rst();
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
